ram_fifo_ctrl: RTL
==================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width on the push/pop and memory data ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, memory address width; depth = 2**ADDR_WIDTH (32).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  push request.
REQ-006 SHALL have port din  input  DATA_WIDTH  push data.
REQ-007 SHALL have port rd_en  input  1  pop request.
REQ-008 SHALL have port dout  output  DATA_WIDTH  pop data.
REQ-009 SHALL have ports full, empty, wr_ack, wr_err, rd_ack, rd_err  output  1 each  status and acknowledge flags.
REQ-010 SHALL have port data_count  output  ADDR_WIDTH+1  number of stored words, 0..32.
REQ-011 SHALL have ports mem_cen, mem_wen (output, 1), mem_addr (output, ADDR_WIDTH), mem_din (output, DATA_WIDTH), mem_dout (input, DATA_WIDTH): single-port RAM drive; RAM writes on clk edge when cen=1 and wen=1, and returns registered read data on mem_dout one edge after a cen=1, wen=0 request.

Function
REQ-012 SHALL implement a six-state FSM: INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR; state register updates on the rising clk edge.
REQ-013 SHALL decode each cycle from the inputs: wr_en=1 and not full -> WRITE; wr_en=1 and full -> WR_ERROR; wr_en=0, rd_en=1, not empty -> READ; wr_en=0, rd_en=1, empty -> RD_ERROR; neither -> NO_OP.
REQ-014 SHALL give write priority when wr_en and rd_en are both 1 (single RAM port); the read is dropped with no rd_ack/rd_err.
REQ-015 SHALL, in the request cycle of an accepted write, drive mem_cen=1, mem_wen=1, mem_addr=wr_ptr, mem_din=din combinationally; at that edge wr_ptr += 1 and data_count += 1.
REQ-016 SHALL, in the request cycle of an accepted read, drive mem_cen=1, mem_wen=0, mem_addr=rd_ptr; at that edge rd_ptr += 1 and data_count -= 1.
REQ-017 SHALL drive mem_cen=0, mem_wen=0, mem_addr=0, mem_din=0 in all other cycles; rejected requests never touch the RAM.
REQ-018 SHALL assert wr_ack/wr_err/rd_ack/rd_err for exactly one cycle, in the cycle after the edge that decoded WRITE/WR_ERROR/READ/RD_ERROR.
REQ-019 SHALL drive dout = mem_dout while rd_ack=1 and 0 otherwise; pop latency is one cycle.
REQ-020 SHALL wrap wr_ptr and rd_ptr modulo 32 (31 -> 0) without flags.
REQ-021 SHALL derive full = (data_count == 32) and empty = (data_count == 0) combinationally from the registered count.
REQ-022 SHALL leave pointers, count and RAM contents unchanged on WR_ERROR, RD_ERROR and NO_OP.

Reset
REQ-023 SHALL, on reset=1 at any time, immediately force state INIT, wr_ptr=0, rd_ptr=0, data_count=0, all ack/err=0, dout=0, full=0, empty=1, and all mem_* outputs to 0.
REQ-024 SHALL hold INIT while reset=1 and enter NO_OP on the first edge after release; a request present in that first cycle is decoded normally.
REQ-025 SHALL discard an operation in flight when reset is asserted mid-operation; a pending rd_ack never appears.

Configuration
REQ-026 SHALL, when macro RAM_FIFO_ALMOST_FLAGS_EN is defined, add outputs almost_full (data_count >= 31) and almost_empty (data_count <= 1), both 0/1 respectively after reset.
REQ-027 SHALL, when RAM_FIFO_ALMOST_FLAGS_EN is undefined, have neither port and no associated logic.

Structure
REQ-028 SHALL take state encodings (3-bit localparams for INIT..RD_ERROR) and the default depth/width constants from shared package ram_fifo_pkg.
REQ-029 SHALL place next-pointer/next-count arithmetic in one sub-module ram_fifo_cal_addr; FSM and output decode stay in ram_fifo_ctrl.

Verification
REQ-030 Reset then idle -> empty=1, full=0, data_count=0, mem_cen=0, dout=0.
REQ-031 Push 32'h01..32'h20 on 32 consecutive cycles -> 32 wr_ack pulses, mem_addr 0..31, full=1, data_count=32; a 33rd push -> wr_err=1 one cycle, count stays 32, mem_cen=0.
REQ-032 Pop 32 times after REQ-031 -> rd_ack each cycle, dout 32'h01..32'h20 in order, empty=1; a further pop -> rd_err=1, dout=0.
REQ-033 Push 40 and pop 40 words interleaved, with the FIFO never exceeding 8 entries -> pointers wrap past 31, data order preserved, no err flags.
REQ-034 With 1 word stored, wr_en=rd_en=1 -> write accepted, count=2, no rd_ack/rd_err; then reset mid-pop -> count=0, no rd_ack.
REQ-035 Build with RAM_FIFO_ALMOST_FLAGS_EN, fill to 31 -> almost_full=1, full=0; drain to 1 -> almost_empty=1, empty=0.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// Shared constants and state encoding for the single-port-RAM FIFO controller.
`timescale 1ns/1ps
package ram_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    localparam logic [2:0] ST_INIT     = 3'd0;
    localparam logic [2:0] ST_NO_OP    = 3'd1;
    localparam logic [2:0] ST_WRITE    = 3'd2;
    localparam logic [2:0] ST_WR_ERROR = 3'd3;
    localparam logic [2:0] ST_READ     = 3'd4;
    localparam logic [2:0] ST_RD_ERROR = 3'd5;

    typedef enum logic [2:0] {
        INIT     = ST_INIT,
        NO_OP    = ST_NO_OP,
        WRITE    = ST_WRITE,
        WR_ERROR = ST_WR_ERROR,
        READ     = ST_READ,
        RD_ERROR = ST_RD_ERROR
    } state_e;

endpackage

// File: rtl/ram_fifo_cal_addr.sv
// Next-state pointer and occupancy arithmetic for the FIFO controller.
`timescale 1ns/1ps
module ram_fifo_cal_addr
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  do_write,
    input  logic                  do_read,
    input  logic [ADDR_WIDTH-1:0] wr_ptr,
    input  logic [ADDR_WIDTH-1:0] rd_ptr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] wr_ptr_nxt,
    output logic [ADDR_WIDTH-1:0] rd_ptr_nxt,
    output logic [ADDR_WIDTH:0]   count_nxt
);

    // Pointers wrap naturally through the power-of-two address width.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (do_write) begin
            wr_ptr_nxt = wr_ptr + 1'b1;
            count_nxt  = count + 1'b1;
        end else if (do_read) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
            count_nxt  = count - 1'b1;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external single-port RAM; write wins over read.
// Optional almost_full/almost_empty outputs under RAM_FIFO_ALMOST_FLAGS_EN.
`timescale 1ns/1ps
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  mem_cen,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    // state    | meaning
    // INIT     | held in reset
    // NO_OP    | previous cycle had no request
    // WRITE    | previous cycle pushed a word (wr_ack)
    // WR_ERROR | previous cycle pushed into a full FIFO (wr_err)
    // READ     | previous cycle popped; RAM data valid now (rd_ack)
    // RD_ERROR | previous cycle popped an empty FIFO (rd_err)

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    do_write, do_read;

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);

    always_comb begin
        state_d = NO_OP;
        if (wr_en) begin
            state_d = full ? WR_ERROR : WRITE;
        end else if (rd_en) begin
            state_d = empty ? RD_ERROR : READ;
        end
    end

    assign do_write = (state_d == WRITE);
    assign do_read  = (state_d == READ);

    // RAM drive is combinational in the request cycle and silenced during reset.
    always_comb begin
        mem_cen  = 1'b0;
        mem_wen  = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (!reset) begin
            if (do_write) begin
                mem_cen  = 1'b1;
                mem_wen  = 1'b1;
                mem_addr = wr_ptr_q;
                mem_din  = din;
            end else if (do_read) begin
                mem_cen  = 1'b1;
                mem_addr = rd_ptr_q;
            end
        end
    end

    ram_fifo_cal_addr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cal_addr (
        .do_write   (do_write),
        .do_read    (do_read),
        .wr_ptr     (wr_ptr_q),
        .rd_ptr     (rd_ptr_q),
        .count      (count_q),
        .wr_ptr_nxt (wr_ptr_d),
        .rd_ptr_nxt (rd_ptr_d),
        .count_nxt  (count_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= INIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ack     = (state_q == WRITE);
    assign wr_err     = (state_q == WR_ERROR);
    assign rd_ack     = (state_q == READ);
    assign rd_err     = (state_q == RD_ERROR);
    assign dout       = rd_ack ? mem_dout : '0;
    assign data_count = count_q;

`ifdef RAM_FIFO_ALMOST_FLAGS_EN
    assign almost_full  = (count_q >= (DEPTH - 1'b1));
    assign almost_empty = (count_q <= {{ADDR_WIDTH{1'b0}}, 1'b1});
`endif

endmodule
